// File: rtl/fetch_queue_if.sv
// Port bundle between the instruction prefetch queue and its surroundings
// (instruction memory, decode handshake, branch redirect).
interface fetch_queue_if #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 32
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic              flush;
    logic [ADDR_W-1:0] redirect_pc;
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic [DATA_W-1:0] imem_rdata;
    logic              deq_ready;
    logic              deq_valid;
    logic [DATA_W-1:0] deq_instr;
    logic [ADDR_W-1:0] deq_pc;
    logic [ADDR_W-1:0] deq_pcplus1;
    logic [CNT_W-1:0]  count;
    logic              full;
    logic              empty;

    // Environment side: memory, decode and branch unit.
    modport master (
        output flush, redirect_pc, imem_rdata, deq_ready,
        input  imem_req, imem_addr, deq_valid, deq_instr, deq_pc, deq_pcplus1,
               count, full, empty
    );

    // Queue side.
    modport slave (
        input  flush, redirect_pc, imem_rdata, deq_ready,
        output imem_req, imem_addr, deq_valid, deq_instr, deq_pc, deq_pcplus1,
               count, full, empty
    );
endinterface

// File: rtl/fetch_queue.sv
// Instruction prefetch queue: owns the sequential fetch PC, issues credit-limited
// reads to a one-cycle-latency memory and buffers {instr, pc, pc+1} for decode.
module fetch_queue #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 32
) (
    input logic         clk,
    input logic         rst,
    fetch_queue_if.slave bus
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned OCC_W = CNT_W + 1;

    typedef struct packed {
        logic [DATA_W-1:0] instr;
        logic [ADDR_W-1:0] pc;
        logic [ADDR_W-1:0] pcPlus1;
    } entry_t;

    entry_t            entries [DEPTH];
    logic [ADDR_W-1:0] fetchPc;
    logic [ADDR_W-1:0] reqPc;
    logic              inflight;
    logic [PTR_W-1:0]  rdPtr;
    logic [PTR_W-1:0]  wrPtr;
    logic [CNT_W-1:0]  count;

    logic              deqValid_c;
    logic              deqFire_c;
    logic              issue_c;
    logic              write_c;
    logic [OCC_W-1:0]  occupancy_c;
    entry_t            head_c;

    // Credit check: a slot is reserved for every outstanding read, so a
    // response can never land on a full queue.
    always_comb begin
        deqValid_c  = (count != '0) & ~bus.flush;
        deqFire_c   = deqValid_c & bus.deq_ready;
        occupancy_c = OCC_W'(count) + OCC_W'(inflight);
        if (deqFire_c) begin
            occupancy_c = occupancy_c - OCC_W'(1);
        end
        issue_c = rst & ~bus.flush & (occupancy_c < OCC_W'(DEPTH));
        write_c = inflight & ~bus.flush;
        head_c  = entries[rdPtr];
    end

    assign bus.imem_req    = issue_c;
    assign bus.imem_addr   = fetchPc;
    assign bus.deq_valid   = deqValid_c;
    assign bus.deq_instr   = head_c.instr;
    assign bus.deq_pc      = head_c.pc;
    assign bus.deq_pcplus1 = head_c.pcPlus1;
    assign bus.count       = count;
    assign bus.full        = (count == CNT_W'(DEPTH));
    assign bus.empty       = (count == '0);

    // Control state; flush wins over every other update.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetchPc  <= '0;
            reqPc    <= '0;
            inflight <= 1'b0;
            rdPtr    <= '0;
            wrPtr    <= '0;
            count    <= '0;
        end else if (bus.flush) begin
            fetchPc  <= bus.redirect_pc;
            inflight <= 1'b0;
            rdPtr    <= '0;
            wrPtr    <= '0;
            count    <= '0;
        end else begin
            inflight <= issue_c;
            if (issue_c) begin
                fetchPc <= fetchPc + ADDR_W'(1);
                reqPc   <= fetchPc;
            end
            if (write_c) begin
                wrPtr <= wrPtr + PTR_W'(1);
            end
            if (deqFire_c) begin
                rdPtr <= rdPtr + PTR_W'(1);
            end
            unique case ({write_c, deqFire_c})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry storage needs no reset; occupancy alone qualifies it.
    always_ff @(posedge clk) begin
        if (write_c) begin
            entries[wrPtr] <= '{instr:   bus.imem_rdata,
                                pc:      reqPc,
                                pcPlus1: reqPc + ADDR_W'(1)};
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed vector table from reset, then directed and
// random sequences checked against a queue-of-PCs reference model.
module tb_fetch_queue;
    localparam int DEPTH  = 4;
    localparam int ADDR_W = 8;
    localparam int DATA_W = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fetch_queue_if #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    fetch_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [31:0] word(input logic [7:0] a);
        return {8'hC3, a, ~a, a ^ 8'h5A};
    endfunction

    // Synchronous instruction memory: data appears the cycle after the address.
    always @(posedge clk) bus.imem_rdata <= word(bus.imem_addr);

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: buffered PCs, the outstanding read, and the fetch PC.
    logic [7:0] mQ[$];
    bit         mInflight;
    logic [7:0] mInflightPc;
    logic [7:0] mFetch;
    logic [7:0] lastPop;

    task automatic modelReset();
        mQ.delete();
        mInflight = 1'b0;
        mFetch    = 8'h00;
    endtask

    task automatic cyc(input bit f, input logic [7:0] rpc, input bit rdy);
        bit         expPop;
        bit         expReq;
        int         occ;
        logic [7:0] head;
        logic [7:0] headNext;
        bus.flush       = f;
        bus.redirect_pc = rpc;
        bus.deq_ready   = rdy;
        #1;
        expPop = rdy && !f && (mQ.size() > 0);
        occ    = mQ.size() + int'(mInflight) - int'(expPop);
        expReq = !f && (occ < DEPTH);
        chk("imem_req", 32'(bus.imem_req), 32'(expReq));
        chk("imem_addr", 32'(bus.imem_addr), 32'(mFetch));
        chk("deq_valid", 32'(bus.deq_valid), 32'(!f && (mQ.size() > 0)));
        chk("count", 32'(bus.count), 32'(mQ.size()));
        chk("count_bound", 32'(bus.count <= 3'(DEPTH)), 32'd1);
        chk("full", 32'(bus.full), 32'(mQ.size() == DEPTH));
        chk("empty", 32'(bus.empty), 32'(mQ.size() == 0));
        if (!f && (mQ.size() > 0)) begin
            head     = mQ[0];
            headNext = head + 8'd1;
            chk("deq_pc", 32'(bus.deq_pc), 32'(head));
            chk("deq_pcplus1", 32'(bus.deq_pcplus1), 32'(headNext));
            chk("deq_instr", bus.deq_instr, word(head));
        end
        if (f) begin
            mQ.delete();
            mInflight = 1'b0;
            mFetch    = rpc;
        end else begin
            if (expPop) lastPop = mQ.pop_front();
            if (mInflight) mQ.push_back(mInflightPc);
            mInflight   = expReq;
            mInflightPc = mFetch;
            if (expReq) mFetch = mFetch + 8'd1;
        end
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        bit         rdy;
        bit         req;
        logic [7:0] addr;
        bit         valid;
        logic [7:0] pc;
        int         cnt;
        bit         full;
    } vec_t;

    vec_t tbl[12];

    initial begin
        tbl[0]  = '{1'b0, 1'b1, 8'h00, 1'b0, 8'h00, 0, 1'b0};
        tbl[1]  = '{1'b0, 1'b1, 8'h01, 1'b0, 8'h00, 0, 1'b0};
        tbl[2]  = '{1'b0, 1'b1, 8'h02, 1'b1, 8'h00, 1, 1'b0};
        tbl[3]  = '{1'b0, 1'b1, 8'h03, 1'b1, 8'h00, 2, 1'b0};
        tbl[4]  = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h00, 3, 1'b0};
        tbl[5]  = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h00, 4, 1'b1};
        tbl[6]  = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h00, 4, 1'b1};
        tbl[7]  = '{1'b1, 1'b1, 8'h04, 1'b1, 8'h00, 4, 1'b1};
        tbl[8]  = '{1'b1, 1'b1, 8'h05, 1'b1, 8'h01, 3, 1'b0};
        tbl[9]  = '{1'b1, 1'b1, 8'h06, 1'b1, 8'h02, 3, 1'b0};
        tbl[10] = '{1'b1, 1'b1, 8'h07, 1'b1, 8'h03, 3, 1'b0};
        tbl[11] = '{1'b1, 1'b1, 8'h08, 1'b1, 8'h04, 3, 1'b0};

        rst             = 1'b0;
        bus.flush       = 1'b0;
        bus.redirect_pc = 8'h00;
        bus.deq_ready   = 1'b0;
        lastPop         = 8'h00;
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_imem_req", 32'(bus.imem_req), 32'd0);
        chk("rst_imem_addr", 32'(bus.imem_addr), 32'd0);
        chk("rst_deq_valid", 32'(bus.deq_valid), 32'd0);
        chk("rst_empty", 32'(bus.empty), 32'd1);
        chk("rst_full", 32'(bus.full), 32'd0);
        chk("rst_count", 32'(bus.count), 32'd0);
        rst = 1'b1;

        // Fill with decode stalled, then drain.
        for (int i = 0; i < 12; i++) begin
            bus.deq_ready = tbl[i].rdy;
            #1;
            chk("tbl_imem_req", 32'(bus.imem_req), 32'(tbl[i].req));
            if (tbl[i].req) chk("tbl_imem_addr", 32'(bus.imem_addr), 32'(tbl[i].addr));
            chk("tbl_deq_valid", 32'(bus.deq_valid), 32'(tbl[i].valid));
            chk("tbl_count", 32'(bus.count), 32'(tbl[i].cnt));
            chk("tbl_full", 32'(bus.full), 32'(tbl[i].full));
            if (tbl[i].valid) begin
                chk("tbl_deq_pc", 32'(bus.deq_pc), 32'(tbl[i].pc));
                chk("tbl_deq_instr", bus.deq_instr, word(tbl[i].pc));
            end
            @(posedge clk);
            #1;
        end

        // Asynchronous reset with three entries buffered and one read outstanding.
        rst = 1'b0;
        #1;
        chk("async_imem_req", 32'(bus.imem_req), 32'd0);
        chk("async_imem_addr", 32'(bus.imem_addr), 32'd0);
        chk("async_deq_valid", 32'(bus.deq_valid), 32'd0);
        chk("async_count", 32'(bus.count), 32'd0);
        chk("async_empty", 32'(bus.empty), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        modelReset();
        for (int i = 0; i < 8; i++) cyc(1'b0, 8'h00, 1'b1);

        // Stall until three entries are held with a read in flight, then redirect.
        for (int i = 0; i < 10; i++) begin
            if (mQ.size() == 3 && mInflight) break;
            cyc(1'b0, 8'h00, 1'b0);
        end
        chk("pre_flush_state", 32'(mQ.size() == 3 && mInflight), 32'd1);
        cyc(1'b1, 8'h40, 1'b1);
        for (int i = 0; i < 3; i++) cyc(1'b0, 8'h00, 1'b1);
        chk("pop_after_flush", 32'(lastPop), 32'h40);
        for (int i = 0; i < 4; i++) cyc(1'b0, 8'h00, 1'b1);

        // Back-to-back flushes, last redirect near the address wrap.
        cyc(1'b1, 8'h10, 1'b1);
        cyc(1'b1, 8'hFE, 1'b1);
        for (int i = 0; i < 4; i++) cyc(1'b0, 8'h00, 1'b1);
        chk("pop_wrap", 32'(lastPop), 32'hFF);
        for (int i = 0; i < 4; i++) cyc(1'b0, 8'h00, 1'b1);

        // Random decode back-pressure with occasional redirects.
        for (int i = 0; i < 200; i++) begin
            cyc(($urandom_range(0, 31) == 0), 8'($urandom), 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
